// File: rtl/visual_peak_history.sv
`default_nettype none
// ============================================================================
// visual_peak_history : scrolling multi-lane peak history, hold markers, draw modes
// Revision 1.0
// ============================================================================
module visual_peak_history #(
  parameter int CH     = 2,
  parameter int DEPTH  = 64,
  parameter int COL_W  = 8,
  parameter int X0     = 64,
  parameter int Y0     = 0,
  parameter int LANE_H = 160,
  parameter int DECAY  = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iFS,
  input  logic [CH*15-1:0]  iPEAK,
  input  logic [1:0]        iMODE,
  input  logic              iFREEZE,
  input  logic [9:0]        iX,
  input  logic [9:0]        iY,
  output logic [9:0]        oR,
  output logic [9:0]        oG,
  output logic [9:0]        oB
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(COL_W);
  localparam int CW = (DECAY > 1) ? $clog2(DECAY) : 1;
  localparam int LW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [10:0]   c_x0       = 11'(X0);
  localparam logic [10:0]   c_xw       = 11'(DEPTH * COL_W);
  localparam logic [10:0]   c_y0       = 11'(Y0);
  localparam logic [10:0]   c_lane_top = 11'(LANE_H - 1);
  localparam logic [10:0]   c_half     = 11'(LANE_H / 2);
  localparam logic [CW-1:0] c_dec_last = CW'(DECAY - 1);

  // ---------------------------------------------------------------------------
  // History storage and hold tracking
  // ---------------------------------------------------------------------------
  logic [6:0]    mem_q  [CH][DEPTH];
  logic [6:0]    hold_q [CH];
  logic [CW-1:0] cnt_q  [CH];
  logic [AW-1:0] wp_q;
  logic          fs_q;

  logic          w_push;
  logic [6:0]    w_h [CH];
  logic          w_unused_peak_lsbs;

  assign w_push = iFS & ~fs_q & ~iFREEZE;

  always_comb begin
    w_unused_peak_lsbs = 1'b0;
    for (int k = 0; k < CH; k++) begin
      w_h[k]             = iPEAK[15*k+8 +: 7];
      w_unused_peak_lsbs = w_unused_peak_lsbs ^ (^iPEAK[15*k +: 8]);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fs_q <= 1'b0;
      wp_q <= '0;
      for (int k = 0; k < CH; k++) begin
        hold_q[k] <= '0;
        cnt_q[k]  <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[k][d] <= '0;
        end
      end
    end else begin
      fs_q <= iFS;
      if (w_push) begin
        wp_q <= wp_q + 1'b1;
        for (int k = 0; k < CH; k++) begin
          mem_q[k][wp_q] <= w_h[k];
          if (w_h[k] >= hold_q[k]) begin
            hold_q[k] <= w_h[k];
            cnt_q[k]  <= '0;
          end else if (cnt_q[k] == c_dec_last) begin
            hold_q[k] <= (hold_q[k] == 7'd0) ? 7'd0 : hold_q[k] - 7'd1;
            cnt_q[k]  <= '0;
          end else begin
            cnt_q[k] <= cnt_q[k] + 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: decode coordinates, fetch history entry and hold for the lane
  // ---------------------------------------------------------------------------
  logic [10:0]   w_dx;
  logic [10:0]   w_dy;
  logic [10:0]   w_row;
  logic          w_inx;
  logic          w_lane_ok;
  logic [LW-1:0] w_lane;
  logic [AW-1:0] w_col;
  logic [AW-1:0] w_idx;
  logic [6:0]    w_hsel;
  logic [6:0]    w_hold_sel;

  always_comb begin
    w_dx      = {1'b0, iX} - c_x0;
    w_dy      = {1'b0, iY} - c_y0;
    w_inx     = ({1'b0, iX} >= c_x0) && (w_dx < c_xw);
    w_col     = AW'(w_dx >> SW);
    // wp - DEPTH + c folds to wp + c modulo DEPTH; column DEPTH-1 lands on wp-1
    w_idx     = wp_q + w_col;
    w_lane_ok = 1'b0;
    w_lane    = '0;
    w_row     = '0;
    for (int k = 0; k < CH; k++) begin
      if (({1'b0, iY} >= c_y0) &&
          (w_dy >= 11'(k * LANE_H)) && (w_dy < 11'((k + 1) * LANE_H))) begin
        w_lane_ok = 1'b1;
        w_lane    = LW'(k);
        w_row     = w_dy - 11'(k * LANE_H);
      end
    end
    w_hsel     = mem_q[w_lane][w_idx];
    w_hold_sel = hold_q[w_lane];
  end

  logic          s1_vld_q;
  logic [LW-1:0] s1_lane_q;
  logic [10:0]   s1_row_q;
  logic [6:0]    s1_h_q;
  logic [6:0]    s1_hold_q;
  logic [1:0]    s1_mode_q;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_vld_q  <= 1'b0;
      s1_lane_q <= '0;
      s1_row_q  <= '0;
      s1_h_q    <= '0;
      s1_hold_q <= '0;
      s1_mode_q <= '0;
    end else begin
      s1_vld_q  <= w_inx & w_lane_ok;
      s1_lane_q <= w_lane;
      s1_row_q  <= w_row;
      s1_h_q    <= w_hsel;
      s1_hold_q <= w_hold_sel;
      s1_mode_q <= iMODE;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: lit test per draw mode, hold marker, colour assignment
  // ---------------------------------------------------------------------------
  logic [10:0] w_b;
  logic [10:0] w_h11;
  logic [10:0] w_hold11;
  logic [10:0] w_mdiff;
  logic [10:0] w_ddiff;
  logic        w_lit;
  logic        w_marker;
  logic [9:0]  w_val;
  logic [9:0]  r_d;
  logic [9:0]  g_d;
  logic [9:0]  b_d;
  logic [9:0]  r_q;
  logic [9:0]  g_q;
  logic [9:0]  b_q;

  always_comb begin
    w_b      = c_lane_top - s1_row_q;
    w_h11    = {4'b0000, s1_h_q};
    w_hold11 = {4'b0000, s1_hold_q};
    w_mdiff  = (w_b >= c_half) ? (w_b - c_half) : (c_half - w_b);
    w_ddiff  = (w_b >= w_h11) ? (w_b - w_h11) : (w_h11 - w_b);
    w_val    = {s1_h_q, 3'b000};
    case (s1_mode_q)
      2'd0:    w_lit = (w_b >= 11'd1) && (w_b <= w_h11);
      2'd1:    w_lit = (s1_h_q != 7'd0) && (w_mdiff <= {5'b00000, s1_h_q[6:1]});
      2'd2:    w_lit = (s1_h_q != 7'd0) && (w_ddiff <= 11'd1);
      default: w_lit = 1'b0;
    endcase
    w_marker = (s1_mode_q != 2'd3) && (s1_hold_q != 7'd0) && (w_b == w_hold11);

    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (s1_vld_q) begin
      if (w_marker) begin
        r_d = 10'd1023;
        g_d = 10'd1023;
        b_d = 10'd1023;
      end else if (w_lit) begin
        case (int'(s1_lane_q))
          0:       r_d = w_val;
          1:       g_d = w_val;
          2:       b_d = w_val;
          default: begin
            r_d = w_val;
            g_d = w_val;
            b_d = w_val;
          end
        endcase
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign oR = r_q;
  assign oG = g_q;
  assign oB = b_q;

endmodule
`default_nettype wire

// File: tb/tb_visual_peak_history.sv
`default_nettype none
// ============================================================================
// tb_visual_peak_history : directed self-checking bench, default parameters
// Revision 1.0
// ============================================================================
module tb_visual_peak_history;

  localparam int XC63 = 64 + 63 * 8;   // first pixel of the newest column

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iFS;
  logic [29:0] iPEAK;
  logic [1:0]  iMODE;
  logic        iFREEZE;
  logic [9:0]  iX;
  logic [9:0]  iY;
  logic [9:0]  oR;
  logic [9:0]  oG;
  logic [9:0]  oB;

  int checks = 0;
  int errors = 0;

  always #5 iCLK = ~iCLK;

  visual_peak_history dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iFS     (iFS),
    .iPEAK   (iPEAK),
    .iMODE   (iMODE),
    .iFREEZE (iFREEZE),
    .iX      (iX),
    .iY      (iY),
    .oR      (oR),
    .oG      (oG),
    .oB      (oB)
  );

  function automatic logic [29:0] rgb(input int r, input int g, input int b);
    return {10'(r), 10'(g), 10'(b)};
  endfunction

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
  endtask

  task automatic push(input int h0, input int h1);
    iPEAK = {7'(h1), 8'd0, 7'(h0), 8'd0};
    iFS   = 1'b1;
    tick();
    iFS   = 1'b0;
    tick();
  endtask

  task automatic pix(input int x, input int y, output logic [29:0] got);
    iX = 10'(x);
    iY = 10'(y);
    tick();
    tick();
    got = {oR, oG, oB};
  endtask

  task automatic test_reset();
    logic [29:0] got;
    iX = 10'(XC63);
    iY = 10'd100;
    iRST = 1'b1;
    iFS  = 1'b1;
    tick();
    iFS  = 1'b0;
    tick();
    checks++;
    if ({oR, oG, oB} !== 30'd0) begin
      errors++;
      $display("FAIL reset_out got %h want %h", {oR, oG, oB}, 30'd0);
    end
    iFS  = 1'b1;
    tick();
    iFS  = 1'b0;
    iRST = 1'b0;
    tick();
    pix(XC63, 100, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL reset_area got %h want %h", got, 30'd0); end
    pix(0, 0, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL reset_left got %h want %h", got, 30'd0); end
    pix(XC63, 200, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL reset_lane1 got %h want %h", got, 30'd0); end
  endtask

  task automatic test_single_push();
    logic [29:0] got;
    int          bl[4] = '{1, 2, 64, 126};
    do_reset();
    push(127, 0);
    foreach (bl[i]) begin
      pix(XC63, 159 - bl[i], got);
      checks++;
      if (got !== rgb(1016, 0, 0)) begin
        errors++;
        $display("FAIL single_bar_b%0d got %h want %h", bl[i], got, rgb(1016, 0, 0));
      end
    end
    pix(XC63, 159 - 127, got);
    checks++;
    if (got !== rgb(1023, 1023, 1023)) begin errors++; $display("FAIL single_marker got %h want %h", got, rgb(1023, 1023, 1023)); end
    pix(XC63, 159, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL single_b0 got %h want %h", got, 30'd0); end
    pix(XC63, 159 - 128, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL single_b128 got %h want %h", got, 30'd0); end
    pix(575, 149, got);
    checks++;
    if (got !== rgb(1016, 0, 0)) begin errors++; $display("FAIL single_xlast got %h want %h", got, rgb(1016, 0, 0)); end
    pix(576, 149, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL single_xpast got %h want %h", got, 30'd0); end
    pix(567, 149, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL single_col62 got %h want %h", got, 30'd0); end
    pix(63, 149, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL single_xbefore got %h want %h", got, 30'd0); end
    pix(XC63, 160 + 149, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL single_lane1 got %h want %h", got, 30'd0); end
  endtask

  task automatic test_wrap();
    logic [29:0] got;
    do_reset();
    for (int i = 0; i <= 64; i++) push(i % 128, 5);
    pix(XC63, 159 - 63, got);
    checks++;
    if (got !== rgb(512, 0, 0)) begin errors++; $display("FAIL wrap_new_b63 got %h want %h", got, rgb(512, 0, 0)); end
    pix(XC63, 159 - 64, got);
    checks++;
    if (got !== rgb(1023, 1023, 1023)) begin errors++; $display("FAIL wrap_marker got %h want %h", got, rgb(1023, 1023, 1023)); end
    pix(XC63, 159 - 65, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL wrap_new_b65 got %h want %h", got, 30'd0); end
    pix(64, 159 - 1, got);
    checks++;
    if (got !== rgb(8, 0, 0)) begin errors++; $display("FAIL wrap_col0_b1 got %h want %h", got, rgb(8, 0, 0)); end
    pix(71, 159 - 2, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL wrap_col0_b2 got %h want %h", got, 30'd0); end
    pix(72, 159 - 2, got);
    checks++;
    if (got !== rgb(16, 0, 0)) begin errors++; $display("FAIL wrap_col1_b2 got %h want %h", got, rgb(16, 0, 0)); end
    pix(XC63, 319 - 3, got);
    checks++;
    if (got !== rgb(0, 40, 0)) begin errors++; $display("FAIL wrap_lane1 got %h want %h", got, rgb(0, 40, 0)); end
  endtask

  task automatic test_hold_decay();
    logic [29:0] got;
    int          exp_hold[8] = '{100, 100, 100, 99, 99, 99, 99, 98};
    do_reset();
    push(100, 0);
    for (int j = 0; j < 8; j++) begin
      push(10, 0);
      pix(XC63, 159 - exp_hold[j], got);
      checks++;
      if (got !== rgb(1023, 1023, 1023)) begin
        errors++;
        $display("FAIL decay_step%0d got %h want %h", j, got, rgb(1023, 1023, 1023));
      end
      pix(XC63, 159 - exp_hold[j] - 1, got);
      checks++;
      if (got !== 30'd0) begin
        errors++;
        $display("FAIL decay_above%0d got %h want %h", j, got, 30'd0);
      end
    end
    push(120, 0);
    pix(XC63, 159 - 120, got);
    checks++;
    if (got !== rgb(1023, 1023, 1023)) begin errors++; $display("FAIL decay_newmax got %h want %h", got, rgb(1023, 1023, 1023)); end
  endtask

  task automatic test_modes();
    logic [29:0] got;
    int          seq[4]  = '{1, 2, 3, 3};
    int          expv[4] = '{320, 0, 320, 0};
    do_reset();
    push(40, 0);
    iMODE = 2'd0;
    iX = 10'(XC63);
    iY = 10'(159 - 39);
    tick(); tick(); tick();
    for (int j = 0; j < 4; j++) begin
      iMODE = 2'(seq[j]);
      tick();
      checks++;
      if ({oR, oG, oB} !== rgb(expv[j], 0, 0)) begin
        errors++;
        $display("FAIL mode_step%0d got %h want %h", j, {oR, oG, oB}, rgb(expv[j], 0, 0));
      end
    end
    tick();
    checks++;
    if ({oR, oG, oB} !== 30'd0) begin errors++; $display("FAIL mode_blank got %h want %h", {oR, oG, oB}, 30'd0); end
    iMODE = 2'd1;
    pix(XC63, 159 - 80, got);
    checks++;
    if (got !== rgb(320, 0, 0)) begin errors++; $display("FAIL mirror_mid got %h want %h", got, rgb(320, 0, 0)); end
    pix(XC63, 159 - 100, got);
    checks++;
    if (got !== rgb(320, 0, 0)) begin errors++; $display("FAIL mirror_edge got %h want %h", got, rgb(320, 0, 0)); end
    pix(XC63, 159 - 101, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL mirror_out got %h want %h", got, 30'd0); end
    iMODE = 2'd2;
    pix(XC63, 159 - 41, got);
    checks++;
    if (got !== rgb(320, 0, 0)) begin errors++; $display("FAIL dot_above got %h want %h", got, rgb(320, 0, 0)); end
    pix(XC63, 159 - 42, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL dot_out got %h want %h", got, 30'd0); end
    iMODE = 2'd3;
    pix(XC63, 159 - 40, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL blank_marker got %h want %h", got, 30'd0); end
    iMODE = 2'd0;
    pix(XC63, 159 - 40, got);
    checks++;
    if (got !== rgb(1023, 1023, 1023)) begin errors++; $display("FAIL bar_marker got %h want %h", got, rgb(1023, 1023, 1023)); end
  endtask

  task automatic test_freeze();
    logic [29:0] got;
    do_reset();
    push(50, 0);
    iFREEZE = 1'b1;
    for (int i = 0; i < 5; i++) push(10, 0);
    iFREEZE = 1'b0;
    pix(XC63, 159 - 49, got);
    checks++;
    if (got !== rgb(400, 0, 0)) begin errors++; $display("FAIL freeze_mem got %h want %h", got, rgb(400, 0, 0)); end
    pix(XC63, 159 - 50, got);
    checks++;
    if (got !== rgb(1023, 1023, 1023)) begin errors++; $display("FAIL freeze_hold got %h want %h", got, rgb(1023, 1023, 1023)); end
    pix(XC63 - 8, 159 - 1, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL freeze_wp got %h want %h", got, 30'd0); end
    iPEAK = {7'd0, 8'd0, 7'd90, 8'd0};
    iRST  = 1'b1;
    iFS   = 1'b1;
    tick();
    iRST  = 1'b0;
    iFS   = 1'b0;
    tick();
    pix(XC63, 159 - 49, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL rstfs_mem got %h want %h", got, 30'd0); end
    pix(XC63, 159 - 50, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL rstfs_hold got %h want %h", got, 30'd0); end
    pix(XC63, 159 - 90, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL rstfs_nopush got %h want %h", got, 30'd0); end
    push(20, 0);
    pix(XC63, 159 - 19, got);
    checks++;
    if (got !== rgb(160, 0, 0)) begin errors++; $display("FAIL rstfs_after got %h want %h", got, rgb(160, 0, 0)); end
    pix(XC63 - 8, 159 - 1, got);
    checks++;
    if (got !== 30'd0) begin errors++; $display("FAIL rstfs_col62 got %h want %h", got, 30'd0); end
  endtask

  initial begin
    iRST    = 1'b0;
    iFS     = 1'b0;
    iPEAK   = '0;
    iMODE   = 2'd0;
    iFREEZE = 1'b0;
    iX      = '0;
    iY      = '0;
    test_reset();
    test_single_push();
    test_wrap();
    test_hold_decay();
    test_modes();
    test_freeze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
